// File: rtl/sevenseg_scan_ctl.sv
// Time-multiplexed seven-segment scan controller: double-buffered digit words,
// per-slot anode sequencing with an anode-off guard, and leading-zero blanking.
module sevenseg_scan_ctl #(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(NDIG)-1:0] wr_addr,
  input  logic [6:0]              wr_data,
  input  logic                    commit,
  input  logic                    lz_en,
  output logic                    pending,
  output logic [6:0]              dig_data,
  output logic [NDIG-1:0]         an_n,
  output logic                    frame_start
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NDIG);
  localparam logic [6:0] BLANK_WORD = 7'b100_0000;

  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [6:0]    staging [NDIG];
  logic [6:0]    display [NDIG];
  logic [6:0]    disp_nx [NDIG];

  logic            slot_end, frame_end, copy;
  logic [NDIG-1:0] sup;
  logic            lead;
  logic [6:0]      show_word;
  logic [NDIG-1:0] an_nx;

  always_comb begin
    slot_end  = (cnt == CW'(PRESCALE - 1));
    frame_end = slot_end && (idx == IW'(NDIG - 1));
    cnt_nx    = slot_end ? '0 : cnt + CW'(1);
    idx_nx    = idx;
    if (slot_end) idx_nx = frame_end ? '0 : idx + IW'(1);
    // A commit arriving in the frame's last cycle is applied on this same edge.
    copy      = frame_end && (pending || commit);
    disp_nx   = copy ? staging : display;
  end

  // Outputs are computed from the post-edge view (next cnt/idx/display) so
  // that registering them keeps them aligned with the counters.
  always_comb begin
    sup  = '0;
    lead = 1'b1;
    // NOTE: lead is a blocking scratch variable carried across loop iterations;
    // it is defaulted above so no latch is inferred.
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (lead && disp_nx[i] == 7'h00) sup[i] = 1'b1;
      else                             lead   = 1'b0;
    end
    show_word = (lz_en && sup[idx_nx]) ? BLANK_WORD : disp_nx[idx_nx];
  end

  always_comb begin
    an_nx = '1;
    if (int'(cnt_nx) >= BLANK_CYC) an_nx[idx_nx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      an_n        <= '1;
      dig_data    <= BLANK_WORD;
      frame_start <= 1'b0;
      // NOTE: both banks are reset so the display powers up blank; they are
      // only NDIG words deep, so a reset on every entry is cheap.
      for (int i = 0; i < NDIG; i++) begin
        staging[i] <= BLANK_WORD;
        display[i] <= BLANK_WORD;
      end
    end else begin
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      pending     <= frame_end ? 1'b0 : (pending || commit);
      an_n        <= an_nx;
      frame_start <= frame_end;
      if (slot_end) dig_data <= show_word;
      if (copy)     display  <= staging;
      // The copy above reads staging before this write lands.
      if (wr_en && int'(wr_addr) < NDIG) staging[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// Directed bench for sevenseg_scan_ctl: per-cycle anode/frame checks derived from
// the cycle count, plus a scoreboard of expected digit words per slot.
module tb_sevenseg_scan_ctl;

  localparam int NDIG = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME = NDIG * PRESCALE;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [1:0]      wr_addr = '0;
  logic [6:0]      wr_data = '0;
  logic            commit = 1'b0;
  logic            lz_en = 1'b0;
  logic            pending;
  logic [6:0]      dig_data;
  logic [NDIG-1:0] an_n;
  logic            frame_start;

  sevenseg_scan_ctl #(.NDIG(NDIG), .PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .lz_en(lz_en), .pending(pending), .dig_data(dig_data),
    .an_n(an_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] w;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_frame(input int start, input logic [6:0] w0, input logic [6:0] w1,
                            input logic [6:0] w2, input logic [6:0] w3);
    sb.push_back('{start, w0});
    sb.push_back('{start + PRESCALE, w1});
    sb.push_back('{start + 2 * PRESCALE, w2});
    sb.push_back('{start + 3 * PRESCALE, w3});
  endtask

  // Checks valid in every cycle after reset release, plus scoreboard pops.
  task automatic sample();
    logic [3:0] ea;
    exp_t       e;
    ea = 4'b1111;
    if (cyc % PRESCALE >= BLANK_CYC) ea[(cyc / PRESCALE) % NDIG] = 1'b0;
    chk("an_n", {28'b0, an_n}, {28'b0, ea});
    chk("frame_start", {31'b0, frame_start}, {31'b0, (cyc % FRAME == 0) && (cyc != 0)});
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("dig_data@%0d", e.cyc), {25'b0, dig_data}, {25'b0, e.w});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic wr(input int at, input logic [1:0] a, input logic [6:0] d);
    run_to(at);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_commit(input int at);
    run_to(at);
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Reset then free-run, with staging writes and a commit inside frame 0.
    repeat (2) @(posedge clk);
    release_reset();
    push_frame(0, 7'h40, 7'h40, 7'h40, 7'h40);
    push_frame(FRAME, 7'h01, 7'h02, 7'h23, 7'h04);
    chk("rst_dig", {25'b0, dig_data}, 32'h40);
    chk("rst_pending", {31'b0, pending}, 32'h0);
    sample();
    wr(1, 2'd0, 7'h01);
    wr(2, 2'd1, 7'h02);
    wr(3, 2'd2, 7'h23);
    wr(4, 2'd3, 7'h04);
    run_to(5);
    chk("pend_pre", {31'b0, pending}, 32'h0);
    do_commit(5);
    chk("pend_rise", {31'b0, pending}, 32'h1);
    run_to(31);
    chk("pend_hold", {31'b0, pending}, 32'h1);
    run_to(32);
    chk("pend_fall", {31'b0, pending}, 32'h0);

    // Staging write with no commit leaves the display unchanged for 3 frames.
    push_frame(2 * FRAME, 7'h01, 7'h02, 7'h23, 7'h04);
    push_frame(3 * FRAME, 7'h01, 7'h02, 7'h23, 7'h04);
    push_frame(4 * FRAME, 7'h01, 7'h02, 7'h23, 7'h04);
    wr(35, 2'd2, 7'h0F);
    run_to(36);
    chk("no_commit_pend", {31'b0, pending}, 32'h0);

    // Boundary collision: commit + write in the last cycle of frame 4.
    push_frame(5 * FRAME, 7'h01, 7'h02, 7'h0F, 7'h04);
    run_to(5 * FRAME - 1);
    commit = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 7'h09;
    step();
    commit = 1'b0; wr_en = 1'b0;
    chk("coll_pend0", {31'b0, pending}, 32'h0);
    step();
    chk("coll_pend1", {31'b0, pending}, 32'h0);
    // Recommit to expose the post-collision staging entry (idx 1 = 09).
    push_frame(6 * FRAME, 7'h01, 7'h09, 7'h0F, 7'h04);
    do_commit(165);
    chk("recommit_pend", {31'b0, pending}, 32'h1);
    run_to(6 * FRAME - 1);
    chk("recommit_hold", {31'b0, pending}, 32'h1);
    run_to(6 * FRAME);
    chk("recommit_fall", {31'b0, pending}, 32'h0);

    // Leading-zero suppression.
    lz_en = 1'b1;
    wr(193, 2'd0, 7'h00);
    wr(194, 2'd1, 7'h05);
    wr(195, 2'd2, 7'h00);
    wr(196, 2'd3, 7'h00);
    do_commit(197);
    push_frame(7 * FRAME, 7'h00, 7'h05, 7'h40, 7'h40);
    wr(225, 2'd3, 7'h20);
    do_commit(226);
    push_frame(8 * FRAME, 7'h00, 7'h05, 7'h00, 7'h20);
    wr(260, 2'd3, 7'h00);
    do_commit(261);
    // lz_en drops mid-frame; the remaining slots show raw zeros.
    push_frame(9 * FRAME, 7'h00, 7'h05, 7'h00, 7'h00);
    run_to(300);
    lz_en = 1'b0;
    run_to(10 * FRAME);
    chk("sb_drained_a", sb.size(), 32'd0);

    // Restart, load a digit, arm a commit, then reset mid-slot.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    release_reset();
    sb.delete();
    push_frame(0, 7'h40, 7'h40, 7'h40, 7'h40);
    sb.push_back('{FRAME, 7'h40});
    sb.push_back('{FRAME + PRESCALE, 7'h07});
    sample();
    wr(1, 2'd1, 7'h07);
    do_commit(2);
    chk("seg2_pend", {31'b0, pending}, 32'h1);
    do_commit(42);
    run_to(45);
    chk("pre_rst_pend", {31'b0, pending}, 32'h1);
    chk("pre_rst_dig", {25'b0, dig_data}, 32'h07);
    #2;
    rst = 1'b1;
    #1;
    chk("async_an_n", {28'b0, an_n}, 32'hF);
    chk("async_dig", {25'b0, dig_data}, 32'h40);
    chk("async_pend", {31'b0, pending}, 32'h0);
    chk("async_fs", {31'b0, frame_start}, 32'h0);
    chk("sb_drained_b", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    push_frame(0, 7'h40, 7'h40, 7'h40, 7'h40);
    sb.push_back('{FRAME, 7'h40});
    sample();
    run_to(FRAME + 1);
    chk("post_rst_pend", {31'b0, pending}, 32'h0);
    run_to(FRAME + PRESCALE);
    chk("sb_drained_c", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
